// File: rtl/hi_15_tag_tx.sv
// ISO15693 VICC response transmitter: single-subcarrier Manchester frame (SOF, data LSB first, EOF)
// driven out as a registered load-modulation bit. All state advances on the falling carrier edge.
module hi_15_tag_tx #(
  parameter int SC_DIV        = 32,
  parameter int HALF_BIT_SC   = 8,
  parameter int SOF_EOF_SC    = 24,
  parameter int LOW_RATE_MULT = 4
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       start,
  input  logic       low_rate,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       mod_out,
  output logic       underflow,
  output logic       dbg
);

  localparam int FC_W  = $clog2(SC_DIV);
  localparam int SEG_W = 12;

  localparam logic [SEG_W-1:0] LONG_LAST_HI = SEG_W'(SOF_EOF_SC * SC_DIV - 1);
  localparam logic [SEG_W-1:0] LONG_LAST_LO = SEG_W'(SOF_EOF_SC * SC_DIV * LOW_RATE_MULT - 1);
  localparam logic [SEG_W-1:0] BIT_LAST_HI  = SEG_W'(2 * HALF_BIT_SC * SC_DIV - 1);
  localparam logic [SEG_W-1:0] BIT_LAST_LO  = SEG_W'(2 * HALF_BIT_SC * SC_DIV * LOW_RATE_MULT - 1);
  localparam logic [SEG_W-1:0] HALF_HI      = SEG_W'(HALF_BIT_SC * SC_DIV);
  localparam logic [SEG_W-1:0] HALF_LO      = SEG_W'(HALF_BIT_SC * SC_DIV * LOW_RATE_MULT);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF_UNMOD, S_SOF_MOD, S_SOF_ONE, S_DATA, S_EOF_ZERO, S_EOF_MOD, S_EOF_UNMOD
  } state_t;

  state_t            r_state, w_next;
  logic [FC_W-1:0]   r_fc_cnt;
  logic [SEG_W-1:0]  r_seg_cnt;
  logic              r_low;
  logic [7:0]        r_hold;
  logic              r_hold_last;
  logic              r_hold_full;
  logic [7:0]        r_shift;
  logic              r_cur_last;
  logic [2:0]        r_bit_cnt;
  logic              r_underflow;
  logic              r_mod;
  logic              r_busy;

  logic [SEG_W-1:0]  w_seg_last;
  logic [SEG_W-1:0]  w_half_len;
  logic              w_seg_end;
  logic              w_second_half;
  logic              w_accept;
  logic              w_load;
  logic              w_shift;
  logic              w_set_uf;
  logic              w_mod_seg;

  assign tx_ready  = ~r_hold_full & ~rst;
  assign w_accept  = tx_valid & tx_ready;
  assign busy      = r_busy;
  assign mod_out   = r_mod;
  assign underflow = r_underflow;
  assign dbg       = r_fc_cnt[FC_W-1];

  // Half-bit segments (SOF_ONE, DATA, EOF_ZERO) share one 16T length; the rest are 24T.
  always_comb begin
    w_half_len = r_low ? HALF_LO : HALF_HI;
    case (r_state)
      S_SOF_ONE, S_DATA, S_EOF_ZERO: w_seg_last = r_low ? BIT_LAST_LO : BIT_LAST_HI;
      default:                       w_seg_last = r_low ? LONG_LAST_LO : LONG_LAST_HI;
    endcase
  end

  assign w_seg_end     = (r_seg_cnt == w_seg_last);
  assign w_second_half = (r_seg_cnt >= w_half_len);

  // Next-state logic
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_set_uf = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_next = S_SOF_UNMOD;
      S_SOF_UNMOD: if (w_seg_end) w_next = S_SOF_MOD;
      S_SOF_MOD:   if (w_seg_end) w_next = S_SOF_ONE;
      S_SOF_ONE: begin
        if (w_seg_end) begin
          if (r_hold_full) begin
            w_next = S_DATA;
            w_load = 1'b1;
          end else begin
            w_next   = S_EOF_ZERO;
            w_set_uf = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_seg_end) begin
          if (r_bit_cnt != 3'd7) begin
            w_shift = 1'b1;
          end else if (r_cur_last) begin
            w_next = S_EOF_ZERO;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_next   = S_EOF_ZERO;
            w_set_uf = 1'b1;
          end
        end
      end
      S_EOF_ZERO:  if (w_seg_end) w_next = S_EOF_MOD;
      S_EOF_MOD:   if (w_seg_end) w_next = S_EOF_UNMOD;
      S_EOF_UNMOD: if (w_seg_end) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // NOTE: every register below uses non-blocking assignment so all of them sample
  // the same pre-edge values; a blocking write here would leak into later reads.
  always_ff @(negedge ck_1356meg) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fc_cnt    <= '0;
      r_seg_cnt   <= '0;
      r_low       <= 1'b0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cur_last  <= 1'b0;
      r_bit_cnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE) begin
        if (start) begin
          r_fc_cnt    <= '0;
          r_seg_cnt   <= '0;
          r_low       <= low_rate;
          r_underflow <= 1'b0;
        end
      end else if (w_seg_end) begin
        r_fc_cnt  <= '0;
        r_seg_cnt <= '0;
      end else begin
        r_fc_cnt  <= r_fc_cnt + 1'b1;
        r_seg_cnt <= r_seg_cnt + 1'b1;
      end

      if (w_accept) begin
        r_hold      <= tx_byte;
        r_hold_last <= tx_last;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shift    <= r_hold;
        r_cur_last <= r_hold_last;
        r_bit_cnt  <= '0;
      end else if (w_shift) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_set_uf) r_underflow <= 1'b1;
    end
  end

  // Output decode: which half of the current segment carries the subcarrier.
  always_comb begin
    case (r_state)
      S_SOF_MOD, S_EOF_MOD: w_mod_seg = 1'b1;
      S_SOF_ONE:            w_mod_seg = w_second_half;
      S_DATA:               w_mod_seg = r_shift[0] ? w_second_half : ~w_second_half;
      S_EOF_ZERO:           w_mod_seg = ~w_second_half;
      default:              w_mod_seg = 1'b0;
    endcase
  end

  // Registered outputs trail the state by one cycle so mod_out never glitches.
  always_ff @(negedge ck_1356meg) begin
    if (rst) begin
      r_mod  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_mod  <= w_mod_seg & ~r_fc_cnt[FC_W-1];
      r_busy <= (r_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_hi_15_tag_tx.sv
// Directed bench for hi_15_tag_tx: table of whole-frame vectors plus reset/underflow sequences.
// Stimulus and sampling happen on the rising edge, opposite the DUT's falling active edge.
module tb_hi_15_tag_tx;

  logic       ck;
  logic       rst;
  logic       start;
  logic       low_rate;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       busy;
  logic       mod_out;
  logic       underflow;
  logic       dbg;

  int n_checks = 0;
  int n_errs   = 0;

  hi_15_tag_tx dut (
    .ck_1356meg(ck),
    .rst       (rst),
    .start     (start),
    .low_rate  (low_rate),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .mod_out   (mod_out),
    .underflow (underflow),
    .dbg       (dbg)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [7:0] d0, d1, d2;
    int         n;
    bit         low;
    bit         last;
    bit         same_cycle;
    int         exp_busy;
    int         exp_first;
    int         exp_rises;
    bit         exp_uf;
  } vec_t;

  localparam int BUDGET = 40000;

  int rise_cnt [24][2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input vec_t v, input int i);
    case (i)
      0:       return v.d0;
      1:       return v.d1;
      default: return v.d2;
    endcase
  endfunction

  // Runs one frame; aborts with reset at cycle rst_at (0 = never).
  task automatic run_frame(input vec_t v, input int rst_at, input string tag);
    int  k, idx, busy_n, first, rises, m, rel, b, h, nbits;
    bit  prev_mod, seen, done;
    logic [7:0] byte_v;
    m = v.low ? 4 : 1;
    for (int i = 0; i < 24; i++) begin
      rise_cnt[i][0] = 0;
      rise_cnt[i][1] = 0;
    end
    idx = 0;
    low_rate = v.low;
    if (!v.same_cycle) begin
      @(posedge ck);
      tx_byte  = v.d0;
      tx_last  = v.last && (v.n == 1);
      tx_valid = 1'b1;
      for (int t = 0; t < 10; t++) begin
        @(posedge ck);
        if (!tx_ready) break;
      end
      check({tag, " preload_taken"}, int'(tx_ready), 0);
      tx_valid = 1'b0;
      idx = 1;
    end
    @(posedge ck);
    start = 1'b1;
    if (v.same_cycle) begin
      tx_byte  = v.d0;
      tx_last  = v.last && (v.n == 1);
      tx_valid = 1'b1;
    end
    k = 0; busy_n = 0; first = -1; rises = 0; prev_mod = 1'b0; seen = 1'b0; done = 1'b0;
    while (!done && k < BUDGET) begin
      @(posedge ck);
      k++;
      start = (k == 1000);   // start while busy must be ignored
      if (tx_valid && !tx_ready) begin
        idx++;
        tx_valid = 1'b0;
      end
      if (!tx_valid && tx_ready && idx < v.n) begin
        tx_byte  = pick(v, idx);
        tx_last  = v.last && (idx == v.n - 1);
        tx_valid = 1'b1;
      end
      if (k == 3) check({tag, " uf_cleared_by_start"}, int'(underflow), 0);
      if (busy) begin
        busy_n++;
        seen = 1'b1;
      end
      if (mod_out && !prev_mod) begin
        rises++;
        if (first < 0) first = k;
        rel = k - 2 - 2048 * m;
        if (rel >= 0 && rel < 24 * 512 * m) begin
          b = rel / (512 * m);
          h = ((rel % (512 * m)) >= 256 * m) ? 1 : 0;
          rise_cnt[b][h]++;
        end
      end
      prev_mod = mod_out;
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        @(posedge ck);
        check({tag, " rst_mod_out"}, int'(mod_out), 0);
        check({tag, " rst_busy"}, int'(busy), 0);
        check({tag, " rst_tx_ready_low"}, int'(tx_ready), 0);
        rst = 1'b0;
        tx_valid = 1'b0;
        start = 1'b0;
        @(posedge ck);
        check({tag, " post_rst_tx_ready"}, int'(tx_ready), 1);
        check({tag, " post_rst_busy"}, int'(busy), 0);
        check({tag, " post_rst_underflow"}, int'(underflow), 0);
        return;
      end
      if (seen && !busy) done = 1'b1;
    end
    start = 1'b0;
    tx_valid = 1'b0;
    check({tag, " frame_ended_in_budget"}, int'(done), 1);
    check({tag, " busy_cycles"}, busy_n, v.exp_busy);
    check({tag, " first_rise"}, first, v.exp_first);
    check({tag, " rise_count"}, rises, v.exp_rises);
    check({tag, " underflow"}, int'(underflow), int'(v.exp_uf));
    check({tag, " idle_mod_out"}, int'(mod_out), 0);
    nbits = v.n * 8;
    for (int i = 0; i < nbits; i++) begin
      byte_v = pick(v, i / 8);
      h = byte_v[i % 8] ? 1 : 0;
      check($sformatf("%s bit%0d right_half", tag, i), rise_cnt[i][h], 8 * m);
      check($sformatf("%s bit%0d wrong_half", tag, i), rise_cnt[i][1 - h], 0);
    end
  endtask

  vec_t vecs [4];
  vec_t v_rst, v_zero;

  initial begin
    // test 2, 3, 4 and 5 of the frame list; expected values worked out by hand
    vecs[0] = '{d0:8'hA5, d1:8'h00, d2:8'h00, n:1, low:1'b0, last:1'b1, same_cycle:1'b0,
                exp_busy:8192,  exp_first:770,  exp_rises:128, exp_uf:1'b0};
    vecs[1] = '{d0:8'hA5, d1:8'h00, d2:8'h00, n:1, low:1'b1, last:1'b1, same_cycle:1'b0,
                exp_busy:32768, exp_first:3074, exp_rises:512, exp_uf:1'b0};
    vecs[2] = '{d0:8'h12, d1:8'h34, d2:8'h56, n:3, low:1'b0, last:1'b1, same_cycle:1'b1,
                exp_busy:16384, exp_first:770,  exp_rises:256, exp_uf:1'b0};
    vecs[3] = '{d0:8'h5A, d1:8'h00, d2:8'h00, n:1, low:1'b0, last:1'b0, same_cycle:1'b0,
                exp_busy:8192,  exp_first:770,  exp_rises:128, exp_uf:1'b1};
    v_rst   = '{d0:8'h11, d1:8'h22, d2:8'h00, n:2, low:1'b0, last:1'b1, same_cycle:1'b0,
                exp_busy:0,     exp_first:0,    exp_rises:0,   exp_uf:1'b0};
    v_zero  = '{d0:8'h00, d1:8'h00, d2:8'h00, n:1, low:1'b0, last:1'b1, same_cycle:1'b0,
                exp_busy:8192,  exp_first:770,  exp_rises:128, exp_uf:1'b0};

    rst = 1'b1; start = 1'b0; low_rate = 1'b0;
    tx_byte = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    repeat (3) @(posedge ck);
    check("reset tx_ready", int'(tx_ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset mod_out", int'(mod_out), 0);
    check("reset underflow", int'(underflow), 0);
    check("reset dbg", int'(dbg), 0);
    rst = 1'b0;
    @(posedge ck);
    check("reset release tx_ready", int'(tx_ready), 1);

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 0, $sformatf("vec%0d", i));

    repeat (20) @(posedge ck);
    check("underflow sticky in idle", int'(underflow), 1);

    run_frame(v_rst, 3000, "rst_mid");
    run_frame(v_zero, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
